cfu_gemm_ctrl: RTL and testbench

- Parametrised CFU front end for the GEMM accelerator: decodes CFU bus commands, writes the N_BANKS input buffers (single or auto-increment burst), launches the systolic array, reads back lane-selected result words and reports status.
- Sits between the CPU CFU port and the systolic array plus its global buffers.
- Successor of the fixed two-bank controller, adding parametrised bank count, C-word lane select, burst pointer, compute timeout/abort and a registered response path.

---
 rtl/cfu_gemm_ctrl.sv | 158 +++++++++++++++
 tb/tb_cfu_gemm_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfu_gemm_ctrl.sv
// cfu_gemm_ctrl: CFU command front end for the GEMM systolic array and its buffers
//   clk, reset                      clock, async active-high reset
//   cmd_valid/ready/payload_*       CFU command channel (opcode [2:0], funct [9:3], two operands)
//   rsp_valid/ready/payload_*       registered CFU response channel
//   buf_wr_en/index/wdata/rdata     input buffer write strobes, shared index, write data, readback
//   c_rdata                         result buffer word, lane-selected on READ_C
//   batch_mode, tpu_enable/K/B_offset/busy   array launch and handshake
module cfu_gemm_ctrl #(
    parameter int N_BANKS = 2,
    parameter int IDX_W   = 16,
    parameter int C_W     = 128,
    parameter int TIMEOUT = 65535
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [9:0]            cmd_payload_function_id,
    input  logic [31:0]           cmd_payload_inputs_0,
    input  logic [31:0]           cmd_payload_inputs_1,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_payload_outputs_0,
    output logic [N_BANKS-1:0]    buf_wr_en,
    output logic [IDX_W-1:0]      buf_index,
    output logic [31:0]           buf_wdata,
    input  logic [32*N_BANKS-1:0] buf_rdata,
    input  logic [C_W-1:0]        c_rdata,
    output logic                  batch_mode,
    output logic                  tpu_enable,
    output logic [15:0]           tpu_K,
    output logic [31:0]           tpu_B_offset,
    input  logic                  tpu_busy
);
    localparam int LANES = C_W / 32;
    localparam int LW    = LANES > 1 ? $clog2(LANES) : 1;
    localparam logic [2:0] OP_NOOP    = 3'd0;
    localparam logic [2:0] OP_WRITE   = 3'd1;
    localparam logic [2:0] OP_COMPUTE = 3'd2;
    localparam logic [2:0] OP_READ_C  = 3'd3;
    localparam logic [2:0] OP_BURST   = 3'd4;
    localparam logic [2:0] OP_SET_PTR = 3'd5;
    localparam logic [2:0] OP_STATUS  = 3'd6;
    localparam logic [2:0] OP_DEBUG   = 3'd7;

    typedef enum logic [2:0] {IDLE, EXEC_START, EXEC_WAIT, READ_WAIT, RSP} state_t;

    state_t           state, state_nx;
    logic [2:0]       op, op_q;
    logic [6:0]       funct, funct_q;
    logic [IDX_W-1:0] ptr, idx_q;
    logic [LW-1:0]    lane_q;
    logic [31:0]      cyc_cnt, cyc_inc, rsp_q, rsp_nx, c_word, bank_word;
    logic             accept, bank_ok, bank_ok_q, is_wr, timed_out;
    logic             bad_bank, timeout, busy_seen;

    assign op        = cmd_payload_function_id[2:0];
    assign funct     = cmd_payload_function_id[9:3];
    assign accept    = cmd_valid && state == IDLE;
    assign bank_ok   = 32'(funct) < N_BANKS;
    assign bank_ok_q = 32'(funct_q) < N_BANKS;
    assign is_wr     = op == OP_WRITE || op == OP_BURST;
    assign cyc_inc   = &cyc_cnt ? cyc_cnt : cyc_cnt + 32'd1;
    // cyc_cnt already holds EXEC_START plus the earlier wait cycles, so it equals
    // the 1-based wait-cycle number here
    assign timed_out = TIMEOUT != 0 && cyc_cnt == 32'(TIMEOUT);
    // lanes past the end of a non-power-of-two C word shift out to zero
    assign c_word    = 32'(c_rdata >> {lane_q, 5'd0});
    assign bank_word = bank_ok_q ? 32'(buf_rdata >> {funct_q, 5'd0}) : 32'hDEAD_BEEF;

    assign cmd_ready             = state == IDLE;
    assign rsp_valid             = state == RSP;
    assign rsp_payload_outputs_0 = rsp_q;
    assign batch_mode            = state == EXEC_START || state == EXEC_WAIT;
    assign tpu_enable            = state == EXEC_START;
    // writes and buffer reads use the live command so the 1-cycle buffer latency
    // lands in READ_WAIT
    assign buf_wr_en = accept && is_wr && bank_ok ? N_BANKS'(1) << funct : '0;
    assign buf_index = batch_mode ? '0 :
                       accept ? (op == OP_BURST ? ptr : cmd_payload_inputs_0[IDX_W-1:0]) : idx_q;
    assign buf_wdata = accept && is_wr ? (op == OP_BURST ? cmd_payload_inputs_0 : cmd_payload_inputs_1) : '0;

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        rsp_nx   = rsp_q;
        case (state)
            IDLE: if (cmd_valid) begin
                state_nx = op == OP_COMPUTE ? EXEC_START :
                           (op == OP_READ_C || op == OP_DEBUG) ? READ_WAIT : RSP;
                rsp_nx   = op == OP_STATUS ? {28'b0, bad_bank, timeout, busy_seen, 1'b0} :
                                             {31'b0, is_wr && !bank_ok};
            end
            EXEC_START: state_nx = EXEC_WAIT;
            EXEC_WAIT: begin
                state_nx = !tpu_busy || timed_out ? RSP : EXEC_WAIT;
                rsp_nx   = !tpu_busy ? cyc_inc : timed_out ? 32'hFFFF_FFFF : rsp_q;
            end
            READ_WAIT: begin
                state_nx = RSP;
                rsp_nx   = op_q == OP_READ_C ? c_word : bank_word;
            end
            RSP: state_nx = rsp_ready ? IDLE : RSP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            op_q         <= '0;
            funct_q      <= '0;
            idx_q        <= '0;
            lane_q       <= '0;
            ptr          <= '0;
            cyc_cnt      <= '0;
            rsp_q        <= '0;
            bad_bank     <= 1'b0;
            timeout      <= 1'b0;
            busy_seen    <= 1'b0;
            tpu_K        <= '0;
            tpu_B_offset <= '0;
        end else begin
            rsp_q <= rsp_nx;
            if (accept) begin
                op_q    <= op;
                funct_q <= funct;
                idx_q   <= buf_index;
                lane_q  <= LANES > 1 ? cmd_payload_inputs_1[LW-1:0] : '0;
            end
            if (accept && op == OP_BURST && bank_ok)
                ptr <= ptr + 1'b1;
            else if (accept && op == OP_SET_PTR)
                ptr <= cmd_payload_inputs_0[IDX_W-1:0];
            if (accept && is_wr && !bank_ok)
                bad_bank <= 1'b1;
            else if (accept && op == OP_STATUS)
                bad_bank <= 1'b0;
            if (state == EXEC_WAIT && tpu_busy && timed_out)
                timeout <= 1'b1;
            else if (accept && op == OP_STATUS)
                timeout <= 1'b0;
            if (accept && op == OP_COMPUTE)
                busy_seen <= 1'b0;
            else if (state == EXEC_WAIT && tpu_busy)
                busy_seen <= 1'b1;
            if (accept && (op == OP_COMPUTE || (op == OP_NOOP && funct == 7'd0)))
                cyc_cnt <= '0;
            else if (batch_mode)
                cyc_cnt <= cyc_inc;
            if (accept && op == OP_COMPUTE) begin
                tpu_K        <= cmd_payload_inputs_0[15:0];
                tpu_B_offset <= cmd_payload_inputs_1;
            end
        end
endmodule

// File: tb/tb_cfu_gemm_ctrl.sv
// tb_cfu_gemm_ctrl: randomized and directed check of cfu_gemm_ctrl against a transaction-level model
module tb_cfu_gemm_ctrl;
    localparam int NB = 2;
    localparam int IW = 16;
    localparam int CW = 128;
    localparam int TO = 20;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [9:0]        cmd_payload_function_id;
    logic [31:0]       cmd_payload_inputs_0;
    logic [31:0]       cmd_payload_inputs_1;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_payload_outputs_0;
    logic [NB-1:0]     buf_wr_en;
    logic [IW-1:0]     buf_index;
    logic [31:0]       buf_wdata;
    logic [32*NB-1:0]  buf_rdata;
    logic [CW-1:0]     c_rdata;
    logic              batch_mode;
    logic              tpu_enable;
    logic [15:0]       tpu_K;
    logic [31:0]       tpu_B_offset;
    logic              tpu_busy;

    cfu_gemm_ctrl #(.N_BANKS(NB), .IDX_W(IW), .C_W(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_payload_function_id(cmd_payload_function_id),
        .cmd_payload_inputs_0(cmd_payload_inputs_0), .cmd_payload_inputs_1(cmd_payload_inputs_1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_payload_outputs_0(rsp_payload_outputs_0),
        .buf_wr_en(buf_wr_en), .buf_index(buf_index), .buf_wdata(buf_wdata), .buf_rdata(buf_rdata),
        .c_rdata(c_rdata), .batch_mode(batch_mode), .tpu_enable(tpu_enable),
        .tpu_K(tpu_K), .tpu_B_offset(tpu_B_offset), .tpu_busy(tpu_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] c_word_of(input logic [15:0] idx, input int lane);
        logic [7:0] l8;
        l8 = 8'(lane);
        return idx == 16'd7 ? 32'h1111_1111 * 32'(lane + 1) : {idx, l8, 8'h5A};
    endfunction

    function automatic logic [CW-1:0] c_line(input logic [15:0] idx);
        logic [CW-1:0] r;
        for (int l = 0; l < CW / 32; l++) r[32*l +: 32] = c_word_of(idx, l);
        return r;
    endfunction

    // environment: buffers with 1-cycle read latency, result buffer, array busy
    logic        mem_clr;
    logic [31:0] emem [0:NB*65536-1];
    int          busy_n;
    int          busy_left;
    int          en_cnt = 0;
    int          bm_cnt = 0;

    always @(posedge clk)
        if (mem_clr) for (int i = 0; i < NB * 65536; i++) emem[i] <= '0;
        else for (int b = 0; b < NB; b++) if (buf_wr_en[b]) emem[b * 65536 + int'(buf_index)] <= buf_wdata;

    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) buf_rdata[32*b +: 32] <= emem[b * 65536 + int'(buf_index)];
        c_rdata <= c_line(buf_index);
    end

    always @(posedge clk or posedge reset)
        if (reset) busy_left <= 0;
        else if (tpu_enable) busy_left <= busy_n;
        else if (busy_left > 0) busy_left <= busy_left - 1;
    assign tpu_busy = busy_left > 0;

    always @(posedge clk) begin
        if (tpu_enable) en_cnt <= en_cnt + 1;
        if (batch_mode) bm_cnt <= bm_cnt + 1;
    end

    // transaction-level model
    logic [31:0] mmem [int];
    int          m_ptr;
    bit          m_bad, m_to, m_seen;
    logic [NB-1:0] x_wr_en;
    logic [15:0] x_idx;
    logic [31:0] x_wd, x_rsp, x_K, x_off;

    function automatic logic [31:0] mrd(input int k);
        return mmem.exists(k) ? mmem[k] : 32'h0;
    endfunction

    always @(negedge clk) if (!reset) begin
        if (cmd_valid && cmd_ready) begin
            chk("wr_en", 32'(buf_wr_en), 32'(x_wr_en));
            if (x_wr_en != '0) begin
                chk("wr_index", 32'(buf_index), 32'(x_idx));
                chk("wr_data", buf_wdata, x_wd);
            end
        end else chk("wr_en_idle", 32'(buf_wr_en), 32'h0);
        if (batch_mode) begin
            chk("batch_index", 32'(buf_index), 32'h0);
            chk("tpu_K", 32'(tpu_K), x_K);
            chk("tpu_B_offset", tpu_B_offset, x_off);
        end
        if (rsp_valid) begin
            chk("rsp_payload", rsp_payload_outputs_0, x_rsp);
            chk("cmd_ready_in_rsp", 32'(cmd_ready), 32'h0);
        end
        if (tpu_enable) chk("enable_in_batch", 32'(batch_mode), 32'h1);
    end

    task automatic issue(input logic [2:0] op, input logic [6:0] f, input logic [31:0] a,
                         input logic [31:0] b, input int n, input int hold, output logic [31:0] got);
        int lat, xl, en0, bm0;
        logic [15:0] ix;
        bit ok;
        ix = a[15:0];
        ok = int'(f) < NB;
        x_wr_en = '0;
        x_rsp = 32'h0;
        xl = 1;
        case (op)
            3'd1: if (ok) begin
                x_wr_en = NB'(1) << f; x_idx = ix; x_wd = b; mmem[int'(f) * 65536 + int'(ix)] = b;
            end else begin
                m_bad = 1; x_rsp = 32'h1;
            end
            3'd2: begin
                x_K = {16'h0, a[15:0]}; x_off = b; m_seen = n > 0;
                if (n >= TO) begin x_rsp = 32'hFFFF_FFFF; m_to = 1; xl = 2 + TO; end
                else begin x_rsp = 32'(n + 2); xl = n + 3; end
            end
            3'd3: begin x_rsp = c_word_of(ix, int'(b[1:0])); xl = 2; end
            3'd4: if (ok) begin
                x_wr_en = NB'(1) << f; x_idx = 16'(m_ptr); x_wd = a;
                mmem[int'(f) * 65536 + m_ptr] = a; m_ptr = (m_ptr + 1) % 65536;
            end else begin
                m_bad = 1; x_rsp = 32'h1;
            end
            3'd5: m_ptr = int'(ix);
            3'd6: begin x_rsp = {28'h0, m_bad, m_to, m_seen, 1'b0}; m_bad = 0; m_to = 0; end
            3'd7: begin x_rsp = ok ? mrd(int'(f) * 65536 + int'(ix)) : 32'hDEAD_BEEF; xl = 2; end
            default: ;
        endcase
        busy_n = n;
        en0 = en_cnt;
        bm0 = bm_cnt;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_payload_function_id = {f, op};
        cmd_payload_inputs_0 = a;
        cmd_payload_inputs_1 = b;
        @(negedge clk);
        chk("cmd_ready_idle", 32'(cmd_ready), 32'h1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        chk("latency", 32'(lat), 32'(xl));
        got = rsp_payload_outputs_0;
        repeat (hold) begin @(posedge clk); #1; end
        chk("rsp_held", 32'(rsp_valid), 32'h1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_released", 32'(rsp_valid), 32'h0);
        chk("idle_after_rsp", 32'(cmd_ready), 32'h1);
        chk("enable_pulses", 32'(en_cnt - en0), op == 3'd2 ? 32'h1 : 32'h0);
        chk("batch_cycles", 32'(bm_cnt - bm0), op == 3'd2 ? 32'(xl - 1) : 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'h1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        chk({tag, "_rsp_payload"}, rsp_payload_outputs_0, 32'h0);
        chk({tag, "_buf_wr_en"}, 32'(buf_wr_en), 32'h0);
        chk({tag, "_buf_index"}, 32'(buf_index), 32'h0);
        chk({tag, "_buf_wdata"}, buf_wdata, 32'h0);
        chk({tag, "_batch_mode"}, 32'(batch_mode), 32'h0);
        chk({tag, "_tpu_enable"}, 32'(tpu_enable), 32'h0);
        chk({tag, "_tpu_K"}, 32'(tpu_K), 32'h0);
        chk({tag, "_tpu_B_offset"}, tpu_B_offset, 32'h0);
    endtask

    initial begin
        logic [31:0] got, a;
        logic [2:0] op;
        logic [6:0] f;
        int nl [7] = '{0, 1, 2, 10, 19, 20, 27};
        reset = 1'b1;
        mem_clr = 1'b1;
        cmd_valid = 1'b0;
        cmd_payload_function_id = '0;
        cmd_payload_inputs_0 = '0;
        cmd_payload_inputs_1 = '0;
        rsp_ready = 1'b0;
        busy_n = 0;
        x_wr_en = '0; x_idx = '0; x_wd = '0; x_rsp = '0; x_K = '0; x_off = '0;
        m_ptr = 0; m_bad = 0; m_to = 0; m_seen = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        mem_clr = 1'b0;
        reset = 1'b0;

        issue(3'd1, 7'd1, 32'd5, 32'hA5A5_A5A5, 0, 0, got);
        issue(3'd7, 7'd1, 32'd5, 32'h0, 0, 0, got);
        chk("lit_debug_a5", got, 32'hA5A5_A5A5);

        issue(3'd5, 7'd0, 32'h0000_FFFF, 32'h0, 0, 0, got);
        for (int i = 1; i <= 3; i++) issue(3'd4, 7'd0, 32'h1111_0000 + 32'(i), 32'h0, 0, 0, got);
        issue(3'd7, 7'd0, 32'h0000_FFFF, 32'h0, 0, 1, got);
        chk("lit_burst_ffff", got, 32'h1111_0001);
        issue(3'd7, 7'd0, 32'h0, 32'h0, 0, 0, got);
        chk("lit_burst_0000", got, 32'h1111_0002);
        issue(3'd7, 7'd0, 32'h1, 32'h0, 0, 0, got);
        chk("lit_burst_0001", got, 32'h1111_0003);

        issue(3'd2, 7'd0, 32'd16, 32'h0000_0400, 10, 0, got);
        chk("lit_compute_cycles", got, 32'd12);
        issue(3'd2, 7'd0, 32'd8, 32'h0000_0800, 30, 0, got);
        chk("lit_timeout_rsp", got, 32'hFFFF_FFFF);
        issue(3'd6, 7'd0, 32'h0, 32'h0, 0, 0, got);
        chk("lit_status_timeout", got, 32'h6);
        issue(3'd6, 7'd0, 32'h0, 32'h0, 0, 0, got);
        chk("lit_status_reread", got, 32'h2);

        issue(3'd3, 7'd0, 32'd7, 32'd2, 0, 5, got);
        chk("lit_read_c_lane2", got, 32'h3333_3333);
        issue(3'd1, 7'd5, 32'd9, 32'h1234_5678, 0, 0, got);
        chk("lit_bad_bank_rsp", got, 32'h1);
        issue(3'd6, 7'd0, 32'h0, 32'h0, 0, 0, got);
        chk("lit_status_bad_bank", got, 32'hA);
        issue(3'd7, 7'd3, 32'd5, 32'h0, 0, 0, got);
        chk("lit_debug_bad_bank", got, 32'hDEAD_BEEF);

        for (int it = 0; it < 200; it++) begin
            op = 3'($urandom_range(0, 7));
            f = $urandom_range(0, 7) == 0 ? 7'($urandom_range(NB, 127)) : 7'($urandom_range(0, NB - 1));
            a = {16'($urandom), $urandom_range(0, 3) == 0 ? 16'($urandom_range(65533, 65535)) : 16'($urandom_range(0, 15))};
            issue(op, f, a, $urandom, nl[$urandom_range(0, 6)], $urandom_range(0, 3), got);
        end

        x_wr_en = '0;
        x_K = 32'h0000_0ABC;
        x_off = 32'hCAFE_0000;
        busy_n = 1000;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_payload_function_id = {7'd0, 3'd2};
        cmd_payload_inputs_0 = 32'h0000_0ABC;
        cmd_payload_inputs_1 = 32'hCAFE_0000;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_compute_batch", 32'(batch_mode), 32'h1);
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        m_ptr = 0; m_bad = 0; m_to = 0; m_seen = 0;
        issue(3'd6, 7'd0, 32'h0, 32'h0, 0, 0, got);
        chk("lit_status_after_reset", got, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
